// File: rtl/centroid_feeder.sv
// centroid_feeder
//   Producer side of the interpolator's centroid handshake. Centroids from
//   the tracker are buffered in a FIFO and presented one at a time on
//   centroid_x/y/z, announced by a single-cycle centroid_ready pulse. The
//   target is held until the interpolator reports done again.
//
//   Optional build macro: CENTROID_FEEDER_DEADBAND_EN
//     Inputs within DEADBAND (Chebyshev distance) of the last written
//     centroid are discarded and flagged on 'dropped'.
//
// Ports
//   clk_in, rst_n_in         clock, async active-low reset
//   in_x/in_y/in_z, in_valid incoming centroid from tracker
//   in_ready                 FIFO not full (combinational)
//   centroid_x/y/z           held target to interpolator
//   centroid_ready           1-cycle pulse, new target valid
//   interp_done              interpolator idle/finished
//   fifo_count               entries buffered (0..DEPTH)
//   busy                     FSM not idle
//   dropped                  1-cycle pulse, input filtered (deadband build)
//
// state  | meaning
// IDLE   | waiting for a buffered centroid; pops on leaving
// ISSUE  | centroid_ready high for this one cycle
// SETTLE | ignore interp_done while the interpolator lowers it
// BUSY   | wait for interp_done to return high
module centroid_feeder #(
  parameter int X_WIDTH  = 9,
  parameter int Y_WIDTH  = 8,
  parameter int Z_WIDTH  = 9,
  parameter int DEPTH    = 8,
  parameter int DEADBAND = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [X_WIDTH-1:0]         in_x,
  input  logic [Y_WIDTH-1:0]         in_y,
  input  logic [Z_WIDTH-1:0]         in_z,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [X_WIDTH-1:0]         centroid_x,
  output logic [Y_WIDTH-1:0]         centroid_y,
  output logic [Z_WIDTH-1:0]         centroid_z,
  output logic                       centroid_ready,
  input  logic                       interp_done,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       busy,
  output logic                       dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Elaboration-time sanity: empty block only exists for illegal parameters.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEADBAND < 0) begin : g_bad_params
  end

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, BUSY} state_t;

  state_t             state, state_nxt;
  logic [X_WIDTH-1:0] mem_x [DEPTH];
  logic [Y_WIDTH-1:0] mem_y [DEPTH];
  logic [Z_WIDTH-1:0] mem_z [DEPTH];
  logic [AW-1:0]      head, tail;
  logic [CW-1:0]      count;
  logic               full, accept, push, pop, primed;

  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign pop      = (state == IDLE) && (count != '0);

`ifdef CENTROID_FEEDER_DEADBAND_EN
  logic [X_WIDTH-1:0] last_x;
  logic [Y_WIDTH-1:0] last_y;
  logic [Z_WIDTH-1:0] last_z;
  logic               have_last, near, dropped_r;
  logic [X_WIDTH:0]   dx;
  logic [Y_WIDTH:0]   dy;
  logic [Z_WIDTH:0]   dz;

  // Absolute differences one bit wider than the operands so no wrap occurs.
  assign dx = ({1'b0, in_x} >= {1'b0, last_x}) ? ({1'b0, in_x} - {1'b0, last_x})
                                               : ({1'b0, last_x} - {1'b0, in_x});
  assign dy = ({1'b0, in_y} >= {1'b0, last_y}) ? ({1'b0, in_y} - {1'b0, last_y})
                                               : ({1'b0, last_y} - {1'b0, in_y});
  assign dz = ({1'b0, in_z} >= {1'b0, last_z}) ? ({1'b0, in_z} - {1'b0, last_z})
                                               : ({1'b0, last_z} - {1'b0, in_z});

  // Max of the three distances <= DEADBAND is the same as each one being <= it.
  assign near = have_last
             && (dx <= (X_WIDTH+1)'(DEADBAND))
             && (dy <= (Y_WIDTH+1)'(DEADBAND))
             && (dz <= (Z_WIDTH+1)'(DEADBAND));
  assign push    = accept && !near;
  assign dropped = dropped_r;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      last_x    <= '0;
      last_y    <= '0;
      last_z    <= '0;
      have_last <= 1'b0;
      dropped_r <= 1'b0;
    end else begin
      dropped_r <= accept && near;
      if (push) begin
        last_x    <= in_x;
        last_y    <= in_y;
        last_z    <= in_z;
        have_last <= 1'b1;
      end
    end
  end
`else
  assign push    = accept;
  assign dropped = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_x[tail] <= in_x;
      mem_y[tail] <= in_y;
      mem_z[tail] <= in_z;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign fifo_count = count;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = ISSUE;
      // The first point is only latched by the interpolator; it never drops done.
      ISSUE:   state_nxt = primed ? SETTLE : IDLE;
      SETTLE:  state_nxt = BUSY;
      BUSY:    if (interp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    centroid_ready = (state == ISSUE);
    busy           = (state != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      centroid_x <= '0;
      centroid_y <= '0;
      centroid_z <= '0;
      primed     <= 1'b0;
    end else begin
      if (pop) begin
        centroid_x <= mem_x[head];
        centroid_y <= mem_y[head];
        centroid_z <= mem_z[head];
      end
      if (state == ISSUE) primed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_centroid_feeder.sv
module tb_centroid_feeder;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic [8:0] in_x;
  logic [7:0] in_y;
  logic [8:0] in_z;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] centroid_x;
  logic [7:0] centroid_y;
  logic [8:0] centroid_z;
  logic       centroid_ready;
  logic       interp_done;
  logic [3:0] fifo_count;
  logic       busy;
  logic       dropped;

  int total = 0;
  int bad   = 0;

  centroid_feeder #(.X_WIDTH(9), .Y_WIDTH(8), .Z_WIDTH(9), .DEPTH(8), .DEADBAND(2)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_valid(in_valid), .in_ready(in_ready),
    .centroid_x(centroid_x), .centroid_y(centroid_y), .centroid_z(centroid_z),
    .centroid_ready(centroid_ready), .interp_done(interp_done),
    .fifo_count(fifo_count), .busy(busy), .dropped(dropped)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // advance one clock edge, land 1 time unit after it
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input int x, input int y, input int z);
    in_valid = 1'b1;
    in_x = 9'(x);
    in_y = 8'(y);
    in_z = 9'(z);
  endtask

  // step until centroid_ready is seen, bounded
  task automatic wait_ready(input string tag);
    int n = 0;
    while (centroid_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(tag, {31'd0, centroid_ready}, 32'd1);
  endtask

  initial begin
    rst_n_in = 1'b0;
    in_valid = 1'b0;
    in_x = '0; in_y = '0; in_z = '0;
    interp_done = 1'b1;
    #23;
    chk("rst_ready",  {31'd0, centroid_ready}, 32'd0);
    chk("rst_count",  {28'd0, fifo_count}, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_x",      {23'd0, centroid_x}, 32'd0);
    chk("rst_drop",   {31'd0, dropped}, 32'd0);
    rst_n_in = 1'b1;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // first push, unprimed: pulse then straight back to IDLE
    step();
    drive(10, 20, 30);
    step();
    in_valid = 1'b0;
    chk("p1_count", {28'd0, fifo_count}, 32'd1);
    chk("p1_ready_early", {31'd0, centroid_ready}, 32'd0);
    step();
    chk("p1_ready", {31'd0, centroid_ready}, 32'd1);
    chk("p1_xyz", {5'd0, centroid_x, centroid_y, centroid_z}, {5'd0, 9'd10, 8'd20, 9'd30});
    chk("p1_count0", {28'd0, fifo_count}, 32'd0);
    step();
    chk("p1_pulse_end", {31'd0, centroid_ready}, 32'd0);
    chk("p1_idle", {31'd0, busy}, 32'd0);

    // second push, done low for 6 cycles
    drive(15, 20, 30);
    step();
    in_valid = 1'b0;
    step();
    chk("p2_ready", {31'd0, centroid_ready}, 32'd1);
    chk("p2_x", {23'd0, centroid_x}, 32'd15);
    step();
    interp_done = 1'b0;
    chk("p2_settle_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("p2_hold_busy", {31'd0, busy}, 32'd1);
      chk("p2_no_pulse", {31'd0, centroid_ready}, 32'd0);
      chk("p2_x_held", {23'd0, centroid_x}, 32'd15);
    end
    interp_done = 1'b1;
    step();
    chk("p2_idle", {31'd0, busy}, 32'd0);

    // fill: done held low, 9 pushes -> one issued, 8 buffered
    interp_done = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(100 + 10 * i, 20 * i, 200 + 5 * i);
      step();
    end
    chk("full_count", {28'd0, fifo_count}, 32'd8);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    drive(499, 99, 499);
    step();
    in_valid = 1'b0;
    chk("full_blocked", {28'd0, fifo_count}, 32'd8);
    chk("full_busy", {31'd0, busy}, 32'd1);
    chk("full_held_x", {23'd0, centroid_x}, 32'd100);
    chk("full_drop", {31'd0, dropped}, 32'd0);
    interp_done = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      wait_ready("drain_pulse");
      chk("drain_xyz", {5'd0, centroid_x, centroid_y, centroid_z},
          {5'd0, 9'(100 + 10 * k), 8'(20 * k), 9'(200 + 5 * k)});
      step();
    end
    chk("drain_empty", {28'd0, fifo_count}, 32'd0);
    step();
    step();
    chk("drain_idle", {31'd0, busy}, 32'd0);

`ifdef CENTROID_FEEDER_DEADBAND_EN
    // deadband: (10,20,30) written, (11,19,30) dropped, (13,20,30) written
    drive(10, 20, 30);
    step();
    in_valid = 1'b0;
    chk("db_first_drop", {31'd0, dropped}, 32'd0);
    step();
    chk("db_first_pulse", {31'd0, centroid_ready}, 32'd1);
    step(); step(); step();
    chk("db_first_idle", {31'd0, busy}, 32'd0);
    drive(11, 19, 30);
    step();
    in_valid = 1'b0;
    chk("db_near_drop", {31'd0, dropped}, 32'd1);
    chk("db_near_count", {28'd0, fifo_count}, 32'd0);
    step();
    chk("db_near_nopulse", {31'd0, centroid_ready}, 32'd0);
    chk("db_drop_end", {31'd0, dropped}, 32'd0);
    drive(13, 20, 30);
    step();
    in_valid = 1'b0;
    chk("db_far_drop", {31'd0, dropped}, 32'd0);
    chk("db_far_count", {28'd0, fifo_count}, 32'd1);
    step();
    chk("db_far_pulse", {31'd0, centroid_ready}, 32'd1);
    chk("db_far_x", {23'd0, centroid_x}, 32'd13);
    step(); step(); step();
`else
    // equal point twice, done dips one cycle each time
    drive(15, 20, 30);
    step();
    step();
    in_valid = 1'b0;
    chk("eq1_pulse", {31'd0, centroid_ready}, 32'd1);
    chk("eq1_count", {28'd0, fifo_count}, 32'd1);
    step();
    interp_done = 1'b0;
    step();
    interp_done = 1'b1;
    chk("eq1_busy", {31'd0, busy}, 32'd1);
    step();
    chk("eq1_idle", {31'd0, busy}, 32'd0);
    step();
    chk("eq2_pulse", {31'd0, centroid_ready}, 32'd1);
    chk("eq2_count", {28'd0, fifo_count}, 32'd0);
    chk("eq2_x", {23'd0, centroid_x}, 32'd15);
    step();
    interp_done = 1'b0;
    step();
    interp_done = 1'b1;
    step();
    chk("eq2_idle", {31'd0, busy}, 32'd0);
    chk("eq_drop", {31'd0, dropped}, 32'd0);
`endif

    // reset while BUSY with 3 buffered
    interp_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(300 + 40 * i, 50 * i, 40 * i);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("rb_count", {28'd0, fifo_count}, 32'd3);
    chk("rb_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("rb_rst_count", {28'd0, fifo_count}, 32'd0);
    chk("rb_rst_busy", {31'd0, busy}, 32'd0);
    chk("rb_rst_x", {23'd0, centroid_x}, 32'd0);
    #3;
    rst_n_in = 1'b1;
    interp_done = 1'b1;
    step();
    drive(50, 60, 70);
    step();
    in_valid = 1'b0;
    step();
    chk("rb_pulse", {31'd0, centroid_ready}, 32'd1);
    chk("rb_xyz", {5'd0, centroid_x, centroid_y, centroid_z}, {5'd0, 9'd50, 8'd60, 9'd70});
    step();
    chk("rb_unprimed_idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
